// File: rtl/regfile_sb_fwd.sv
// regfile_sb_fwd: parametrised GPR/HI/LO register file with multi-stage forwarding,
// a per-register pending-write scoreboard and a single read-stall request to ID.
module regfile_sb_fwd #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int NRP  = 2,
  parameter int NFWD = 3,
  parameter int SBW  = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NRP-1:0]       rd_en,
  input  logic [NRP*AW-1:0]    raddr,
  output logic [NRP*DW-1:0]    rdata,
  output logic                 stall,
  input  logic                 iss_we,
  input  logic [AW-1:0]        iss_waddr,
  output logic                 iss_full,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [DW-1:0]        wdata,
  input  logic [NFWD-1:0]      fwd_we,
  input  logic [NFWD*AW-1:0]   fwd_waddr,
  input  logic [NFWD*DW-1:0]   fwd_wdata,
  input  logic [NFWD-1:0]      fwd_rdy,
  input  logic                 md_start,
  input  logic                 md_end,
  input  logic                 hi_we,
  input  logic                 lo_we,
  input  logic [DW-1:0]        hi_i,
  input  logic [DW-1:0]        lo_i,
  input  logic [NFWD-1:0]      fwd_hi_we,
  input  logic [NFWD-1:0]      fwd_lo_we,
  input  logic [NFWD*DW-1:0]   fwd_hi,
  input  logic [NFWD*DW-1:0]   fwd_lo,
  input  logic                 hi_rd,
  input  logic                 lo_rd,
  output logic [DW-1:0]        hi_out,
  output logic [DW-1:0]        lo_out,
  input  logic                 flush
);
  localparam int NREG = 2**AW;
  logic [DW-1:0]  regs [NREG];
  logic [SBW-1:0] sb_cnt [NREG];
  logic [DW-1:0]  hi_r, lo_r;
  logic           hilo_pend;
  logic [NRP-1:0] unsat;
  logic           hi_hit, lo_hit, iss_ok;
  for (genvar p = 0; p < NRP; p++) begin : g_rd
    logic [AW-1:0] ra;
    logic          hit, frdy;
    logic [DW-1:0] fd;
    assign ra = raddr[p*AW +: AW];
    // descending scan so the youngest matching stage ends up winning
    always_comb begin
      hit  = 1'b0;
      frdy = 1'b1;
      fd   = '0;
      for (int j = NFWD-1; j >= 0; j--)
        if (fwd_we[j] && fwd_waddr[j*AW +: AW] == ra) begin
          hit  = 1'b1;
          frdy = fwd_rdy[j];
          fd   = fwd_wdata[j*DW +: DW];
        end
    end
    assign rdata[p*DW +: DW] = ra == '0 ? '0 : hit ? fd : (we && waddr == ra) ? wdata : regs[ra];
    assign unsat[p] = ra != '0 && (hit ? !frdy : !(we && waddr == ra) && sb_cnt[ra] != '0);
  end
  always_comb begin
    hi_out = hi_we ? hi_i : hi_r;
    lo_out = lo_we ? lo_i : lo_r;
    for (int j = NFWD-1; j >= 0; j--) begin
      if (fwd_hi_we[j]) hi_out = fwd_hi[j*DW +: DW];
      if (fwd_lo_we[j]) lo_out = fwd_lo[j*DW +: DW];
    end
  end
  assign hi_hit   = hi_we || |fwd_hi_we;
  assign lo_hit   = lo_we || |fwd_lo_we;
  assign stall    = |(rd_en & unsat) || (hilo_pend && ((hi_rd && !hi_hit) || (lo_rd && !lo_hit)));
  assign iss_full = iss_we && &sb_cnt[iss_waddr];
  assign iss_ok   = iss_we && !stall && iss_waddr != '0 && !(&sb_cnt[iss_waddr]);
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      hi_r <= '0;
      lo_r <= '0;
    end else begin
      if (we && waddr != '0) regs[waddr] <= wdata;
      if (hi_we) hi_r <= hi_i;
      if (lo_we) lo_r <= lo_i;
    end
  // an effective issue and an effective commit to the same register cancel out
  always_ff @(posedge clk or negedge resetn)
    if (!resetn || flush) begin
      for (int i = 0; i < NREG; i++) sb_cnt[i] <= '0;
      hilo_pend <= 1'b0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (iss_ok && iss_waddr == AW'(i) && !(we && waddr == AW'(i) && sb_cnt[i] != '0))
          sb_cnt[i] <= sb_cnt[i] + 1'b1;
        else if (we && waddr == AW'(i) && sb_cnt[i] != '0 && !(iss_ok && iss_waddr == AW'(i)))
          sb_cnt[i] <= sb_cnt[i] - 1'b1;
      end
      hilo_pend <= md_end ? 1'b0 : md_start ? 1'b1 : hilo_pend;
    end
endmodule

// File: doc/regfile_sb_fwd.md
Name: regfile_sb_fwd

Overview:
Parametrised successor to the CPU's GPR/HI/LO register file. Adds configurable width, depth, read-port count and forwarding-stage count. A per-register pending-write scoreboard and a HI/LO busy tracker generate a single read-stall request to the ID stage. It sits in ID: it is read by decode, written by WB, and fed forwarding buses from the EX/MEM/WB stages (stage 0 = youngest).

Parameters:
DW, 32, data width
AW, 5, address width; NREG = 2**AW registers
NRP, 2, number of read ports
NFWD, 3, number of forwarding stages; index 0 has the highest priority
SBW, 2, scoreboard counter width per register

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
rd_en  in  NRP  read port i is in use this cycle
raddr  in  NRP*AW  read addresses, port i at [i*AW +: AW]
rdata  out  NRP*DW  read data
stall  out  1  ID must hold; at least one in-use read cannot be satisfied
iss_we  in  1  instruction leaving ID will write GPR iss_waddr
iss_waddr  in  AW  issue destination
iss_full  out  1  scoreboard counter of iss_waddr is saturated
we  in  1  WB commit write
waddr  in  AW  commit address
wdata  in  DW  commit data
fwd_we  in  NFWD  forwarding stage i holds a GPR write
fwd_waddr  in  NFWD*AW  forwarding destination addresses
fwd_wdata  in  NFWD*DW  forwarding data
fwd_rdy  in  NFWD  forwarding data is valid; 0 = load result not yet available
md_start  in  1  mul/div issued; HI/LO pending
md_end  in  1  mul/div result committed
hi_we, lo_we  in  1 each  HI/LO commit enables
hi_i, lo_i  in  DW each  HI/LO commit data
fwd_hi_we, fwd_lo_we  in  NFWD each  HI/LO forwarding enables
fwd_hi, fwd_lo  in  NFWD*DW each  HI/LO forwarding data
hi_rd, lo_rd  in  1 each  ID reads HI / LO
hi_out, lo_out  out  DW each  forwarded HI/LO value
flush  in  1  pipeline flush

Behaviour:
- Reset (async, resetn=0): all GPRs, HI, LO, scoreboard counters and hilo_pend cleared to 0. Every output is 0 apart from ones that follow combinationally from inputs.
- GPR write: on posedge, if we && waddr!=0, reg[waddr] <= wdata. Register 0 is never written.
- Read port i, combinational priority:
  - raddr==0 -> 0.
  - Else the lowest-index stage j with fwd_we[j] && fwd_waddr[j]==raddr: fwd_wdata[j]. If fwd_rdy[j]==0 the port is unsatisfied.
  - Else we && waddr==raddr -> wdata (write-through).
  - Else if sb_cnt[raddr]!=0 -> unsatisfied; rdata returns the array value.
  - Else the array value.
- stall = OR over ports i of (rd_en[i] && unsatisfied[i]), plus the HI/LO term below. No combinational loops; stall does not depend on iss_we.
- Scoreboard, per posedge:
  - Counter of iss_waddr increments when iss_we && !stall && iss_waddr!=0.
  - Counter of waddr decrements when we && waddr!=0 && cnt!=0.
  - Increment and decrement on the same register in the same cycle: the counter is unchanged.
  - iss_full = iss_we && sb_cnt[iss_waddr]==2**SBW-1. The counter never wraps; an issue while full is ignored, and the issuer must treat iss_full as an additional stall.
  - Decrement at 0 is ignored (no underflow).
- HI/LO:
  - hi_out: lowest j with fwd_hi_we[j] -> fwd_hi[j]; else hi_we -> hi_i; else the HI register. lo_out is the same for LO.
  - hilo_pend is set by md_start and cleared by md_end. md_end wins when both are asserted.
  - stall also asserted when (hi_rd||lo_rd) && hilo_pend && no forwarding/commit enable for the read register is active.
  - HI/LO registers are written on posedge by hi_we/lo_we independently.
- flush: on posedge, all scoreboard counters and hilo_pend are cleared. An issue in the same cycle is dropped. Commit writes (we, hi_we, lo_we) still update the arrays.
- Latency: reads are zero-cycle combinational. Writes are visible in the array on the next cycle and through write-through in the same cycle.
- Reset asserted mid-operation clears all state immediately. Reads after release return 0.

Test Plan:
- Reset, then write r5=0x1234_5678 via we. Next cycle raddr0=5 -> rdata0=0x12345678; raddr1=0 -> 0 even with fwd_we[0]=1 fwd_waddr[0]=0.
- fwd stage0 r3=0xAAAA, stage1 r3=0xBBBB, we r3=0xCCCC in the same cycle -> rdata=0xAAAA. Drop stage0 -> 0xBBBB. Drop stage1 -> 0xCCCC.
- Load hazard: fwd_we[0]=1 waddr=7 fwd_rdy[0]=0, rd_en0=1 raddr0=7 -> stall=1. Set rd_en0=0 -> stall=0.
- Issue r9 four times (SBW=2) -> cnt=3, iss_full=1 on the fourth attempt and cnt stays 3. Read r9 with no forwarding -> stall=1. Three commits to r9 -> cnt=0, stall=0. Simultaneous issue and commit of r9 -> cnt unchanged.
- md_start, then hi_rd=1 -> stall=1. md_end with hi_we hi_i=0xDEAD -> hi_out=0xDEAD same cycle. Next cycle stall=0 and hi_out=0xDEAD from the register.
- Issue r4 twice, then flush -> cnt[r4]=0 and read r4 without stall. Assert resetn=0 mid-run -> rdata/hi_out/lo_out read 0 immediately.
